// File: rtl/multicycle_control_unit_if.sv
// Bundle between the multicycle control FSM and the MIPS datapath/memory.
// slave = control unit side, master = datapath side (drives instruction fields and MemReady).
interface multicycle_control_unit_if #(
  parameter int OpCode_WIDTH     = 6,
  parameter int Funct_Width      = 6,
  parameter int ALUControl_WIDTH = 3
);
  logic [OpCode_WIDTH-1:0]     OpCode;
  logic [Funct_Width-1:0]      Funct;
  logic                        Zero_flag;
  // MemReady is the ready half of the memory handshake: the FSM holds an access
  // (FETCH, MEMRD, MEMWR) with its controls stable until MemReady=1, and the access
  // completes in exactly the cycle MemReady=1 is observed.
  logic                        MemReady;
  logic                        IorD;
  logic                        MemWrite;
  logic                        IRWrite;
  logic                        RegDst;
  logic                        MemtoReg;
  logic                        RegWrite;
  logic                        ALUSrcA;
  logic [1:0]                  ALUSrcB;
  logic [1:0]                  PCSrc;
  logic                        PCEn;
  logic [ALUControl_WIDTH-1:0] ALUControl;
  logic                        Illegal_op;
  logic                        Instr_done;
  logic [3:0]                  State;

  modport master (
    output OpCode, Funct, Zero_flag, MemReady,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, PCSrc, PCEn, ALUControl, Illegal_op, Instr_done, State
  );

  modport slave (
    input  OpCode, Funct, Zero_flag, MemReady,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, PCSrc, PCEn, ALUControl, Illegal_op, Instr_done, State
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM with ALU decoder, illegal-opcode and retire pulses.
// Optional macro BNE_SUPPORT_EN adds bne (opcode 000101) through the BRANCH state.
module multicycle_control_unit #(
  parameter int OpCode_WIDTH     = 6,
  parameter int Funct_Width      = 6,
  parameter int ALUControl_WIDTH = 3
) (
  input logic                    clk,
  input logic                    reset,
  multicycle_control_unit_if.slave bus
);
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

  localparam logic [OpCode_WIDTH-1:0] OP_LW    = 6'b100011;
  localparam logic [OpCode_WIDTH-1:0] OP_SW    = 6'b101011;
  localparam logic [OpCode_WIDTH-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OpCode_WIDTH-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OpCode_WIDTH-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OpCode_WIDTH-1:0] OP_BNE   = 6'b000101;
  localparam logic [OpCode_WIDTH-1:0] OP_J     = 6'b000010;

  logic [3:0]                  state, state_next;
  logic [OpCode_WIDTH-1:0]     op;
  logic [Funct_Width-1:0]      funct;
  logic                        iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic                        alu_src_a, pc_write, branch, branch_cond, illegal_op, instr_done;
  logic [1:0]                  alu_src_b, pc_src, alu_op;
  logic [2:0]                  alu3;
  logic [ALUControl_WIDTH-1:0] alu_control;

  assign op    = bus.OpCode;
  assign funct = bus.Funct;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = bus.MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_BEQ:       state_next = S_BRANCH;
`ifdef BNE_SUPPORT_EN
          OP_BNE:       state_next = S_BRANCH;
`endif
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:  state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_next = bus.MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_next = bus.MemReady ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_next = S_ALUWB;
      S_ADDIEX:  state_next = S_ADDIWB;
      default:   state_next = S_FETCH;
    endcase
  end

  always_comb begin
    iord = 1'b0; mem_write = 1'b0; ir_write = 1'b0; reg_dst = 1'b0;
    mem_to_reg = 1'b0; reg_write = 1'b0; alu_src_a = 1'b0; pc_write = 1'b0;
    branch = 1'b0; branch_cond = 1'b0; illegal_op = 1'b0; instr_done = 1'b0;
    alu_src_b = 2'b00; pc_src = 2'b00; alu_op = 2'b00;
    case (state)
      S_FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = bus.MemReady;
        pc_write  = bus.MemReady;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_BEQ, OP_J: illegal_op = 1'b0;
`ifdef BNE_SUPPORT_EN
          OP_BNE: illegal_op = 1'b0;
`endif
          default: illegal_op = 1'b1;
        endcase
        instr_done = illegal_op;
      end
      S_MEMADR:  begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      S_MEMRD:   iord = 1'b1;
      S_MEMWB:   begin mem_to_reg = 1'b1; reg_write = 1'b1; instr_done = 1'b1; end
      S_MEMWR:   begin iord = 1'b1; mem_write = 1'b1; instr_done = bus.MemReady; end
      S_EXECUTE: begin alu_src_a = 1'b1; alu_op = 2'b10; end
      S_ALUWB:   begin reg_dst = 1'b1; reg_write = 1'b1; instr_done = 1'b1; end
      S_ADDIEX:  begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      S_ADDIWB:  begin reg_write = 1'b1; instr_done = 1'b1; end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_op      = 2'b01;
        pc_src      = 2'b01;
        branch      = 1'b1;
        branch_cond = bus.Zero_flag;
`ifdef BNE_SUPPORT_EN
        if (op == OP_BNE) branch_cond = ~bus.Zero_flag;
`endif
        instr_done  = 1'b1;
      end
      S_JUMP:    begin pc_src = 2'b10; pc_write = 1'b1; instr_done = 1'b1; end
      default:   ;
    endcase
  end

  always_comb begin
    alu3 = 3'b010;
    case (alu_op)
      2'b01: alu3 = 3'b100;
      2'b10: begin
        case (funct)
          6'b100000: alu3 = 3'b010;
          6'b100010: alu3 = 3'b100;
          6'b101010: alu3 = 3'b110;
          6'b011100: alu3 = 3'b101;
          6'b100100: alu3 = 3'b000;
          6'b100101: alu3 = 3'b001;
          default:   alu3 = 3'b010;
        endcase
      end
      default: alu3 = 3'b010;
    endcase
    alu_control      = '0;
    alu_control[2:0] = alu3;
  end

  // Reset forces every output low combinationally so nothing writes in the reset cycle.
  assign bus.IorD       = ~reset & iord;
  assign bus.MemWrite   = ~reset & mem_write;
  assign bus.IRWrite    = ~reset & ir_write;
  assign bus.RegDst     = ~reset & reg_dst;
  assign bus.MemtoReg   = ~reset & mem_to_reg;
  assign bus.RegWrite   = ~reset & reg_write;
  assign bus.ALUSrcA    = ~reset & alu_src_a;
  assign bus.ALUSrcB    = reset ? 2'b00 : alu_src_b;
  assign bus.PCSrc      = reset ? 2'b00 : pc_src;
  assign bus.PCEn       = ~reset & (pc_write | (branch & branch_cond));
  assign bus.ALUControl = reset ? '0 : alu_control;
  assign bus.Illegal_op = ~reset & illegal_op;
  assign bus.Instr_done = ~reset & instr_done;
  assign bus.State      = reset ? 4'd0 : state;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle expected output vectors
// are queued as each cycle is driven and popped at the following falling edge.
module tb_multicycle_control_unit;
  logic clk = 1'b0;
  logic reset;

  multicycle_control_unit_if bus ();

  multicycle_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] ADDI = 6'b001000, BEQ = 6'b000100, BNE = 6'b000101;
  localparam logic [5:0] JMP = 6'b000010, BAD = 6'b111111;

  logic [20:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [20:0] obs_vec();
    return {bus.State, bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
            bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.PCSrc, bus.PCEn,
            bus.ALUControl, bus.Illegal_op, bus.Instr_done};
  endfunction

  function automatic logic legal_op(input logic [5:0] op);
    logic l;
    l = (op == LW) || (op == SW) || (op == RT) || (op == ADDI) || (op == BEQ) || (op == JMP);
`ifdef BNE_SUPPORT_EN
    if (op == BNE) l = 1'b1;
`endif
    return l;
  endfunction

  // Expected outputs for one cycle, straight from the per-state control table.
  function automatic logic [20:0] exp_out(input int st, input logic [5:0] op, input logic [5:0] fn,
                                          input logic z, input logic mr);
    logic iord, mw, irw, rdst, m2r, rw, sa, pcen, ill, done;
    logic [1:0] sb, pcs;
    logic [2:0] alu;
    iord = 0; mw = 0; irw = 0; rdst = 0; m2r = 0; rw = 0; sa = 0; pcen = 0; ill = 0; done = 0;
    sb = 2'b00; pcs = 2'b00; alu = 3'b010;
    case (st)
      0:  begin sb = 2'b01; irw = mr; pcen = mr; end
      1:  begin sb = 2'b11; ill = !legal_op(op); done = ill; end
      2:  begin sa = 1; sb = 2'b10; end
      3:  iord = 1;
      4:  begin m2r = 1; rw = 1; done = 1; end
      5:  begin iord = 1; mw = 1; done = mr; end
      6: begin
        sa = 1;
        case (fn)
          6'b100010: alu = 3'b100;
          6'b101010: alu = 3'b110;
          6'b011100: alu = 3'b101;
          6'b100100: alu = 3'b000;
          6'b100101: alu = 3'b001;
          default:   alu = 3'b010;
        endcase
      end
      7:  begin rdst = 1; rw = 1; done = 1; end
      8:  begin sa = 1; alu = 3'b100; pcs = 2'b01; pcen = (op == BNE) ? ~z : z; done = 1; end
      9:  begin sa = 1; sb = 2'b10; end
      10: begin rw = 1; done = 1; end
      11: begin pcs = 2'b10; pcen = 1; done = 1; end
      default: ;
    endcase
    return {4'(st), iord, mw, irw, rdst, m2r, rw, sa, sb, pcs, pcen, alu, ill, done};
  endfunction

  task automatic compare_head(input string tag);
    logic [20:0] o, e;
    @(negedge clk);
    o = obs_vec();
    e = exp_q.pop_front();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int st, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic mr, input string tag);
    // Opcode is scrambled during FETCH: the FSM must not look at it there.
    bus.OpCode    = (st == 0) ? 6'($urandom_range(0, 63)) : op;
    bus.Funct     = fn;
    bus.Zero_flag = z;
    bus.MemReady  = mr;
    exp_q.push_back(exp_out(st, op, fn, z, mr));
    compare_head(tag);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fstall, input int mstall, input string tag);
    int   st_q[$];
    logic mr_q[$];
    for (int i = 0; i < fstall; i++) begin st_q.push_back(0); mr_q.push_back(1'b0); end
    st_q.push_back(0); mr_q.push_back(1'b1);
    st_q.push_back(1); mr_q.push_back(1'($urandom_range(0, 1)));
    case (op)
      LW: begin
        st_q.push_back(2); mr_q.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < mstall; i++) begin st_q.push_back(3); mr_q.push_back(1'b0); end
        st_q.push_back(3); mr_q.push_back(1'b1);
        st_q.push_back(4); mr_q.push_back(1'($urandom_range(0, 1)));
      end
      SW: begin
        st_q.push_back(2); mr_q.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < mstall; i++) begin st_q.push_back(5); mr_q.push_back(1'b0); end
        st_q.push_back(5); mr_q.push_back(1'b1);
      end
      RT:   begin st_q.push_back(6); st_q.push_back(7); mr_q.push_back(1'b0); mr_q.push_back(1'b1); end
      ADDI: begin st_q.push_back(9); st_q.push_back(10); mr_q.push_back(1'b1); mr_q.push_back(1'b0); end
      BEQ:  begin st_q.push_back(8); mr_q.push_back(1'($urandom_range(0, 1))); end
      BNE: begin
`ifdef BNE_SUPPORT_EN
        st_q.push_back(8); mr_q.push_back(1'($urandom_range(0, 1)));
`endif
      end
      JMP:  begin st_q.push_back(11); mr_q.push_back(1'($urandom_range(0, 1))); end
      default: ;
    endcase
    foreach (st_q[i]) step(st_q[i], op, fn, z, mr_q[i], tag);
  endtask

  initial begin
    reset = 1'b1;
    bus.OpCode = 6'b0; bus.Funct = 6'b0; bus.Zero_flag = 1'b0; bus.MemReady = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(21'd0);
    compare_head("reset_outputs");
    reset = 1'b0;

    run_instr(LW,   6'b000000, 1'b0, 0, 0, "lw");
    run_instr(LW,   6'b000000, 1'b1, 2, 2, "lw_stall");
    run_instr(RT,   6'b100010, 1'b0, 0, 0, "rtype_sub");
    run_instr(RT,   6'b100000, 1'b0, 0, 0, "rtype_add");
    run_instr(RT,   6'b101010, 1'b0, 0, 0, "rtype_slt");
    run_instr(RT,   6'b011100, 1'b0, 0, 0, "rtype_mul");
    run_instr(RT,   6'b100100, 1'b0, 1, 0, "rtype_and");
    run_instr(RT,   6'b100101, 1'b1, 0, 0, "rtype_or");
    run_instr(RT,   6'b111000, 1'b0, 0, 0, "rtype_unknown");
    run_instr(ADDI, 6'b000000, 1'b0, 0, 0, "addi");
    run_instr(BEQ,  6'b000000, 1'b1, 0, 0, "beq_taken");
    run_instr(BEQ,  6'b000000, 1'b0, 0, 0, "beq_not_taken");
    run_instr(SW,   6'b000000, 1'b0, 0, 3, "sw_stall");
    run_instr(SW,   6'b000000, 1'b0, 0, 0, "sw");
    run_instr(JMP,  6'b000000, 1'b0, 0, 0, "jump");
    run_instr(BAD,  6'b000000, 1'b0, 0, 0, "illegal");
    run_instr(BNE,  6'b000000, 1'b1, 0, 0, "bne_z1");
    run_instr(BNE,  6'b000000, 1'b0, 0, 0, "bne_z0");

    // Store abandoned by reset while stalled in MEMWR.
    step(0, SW, 6'b0, 1'b0, 1'b1, "rst_mid_fetch");
    step(1, SW, 6'b0, 1'b0, 1'b1, "rst_mid_decode");
    step(2, SW, 6'b0, 1'b0, 1'b0, "rst_mid_memadr");
    step(5, SW, 6'b0, 1'b0, 1'b0, "rst_mid_memwr");
    reset = 1'b1;
    bus.MemReady = 1'b0;
    exp_q.push_back(21'd0);
    compare_head("rst_mid_forced");
    reset = 1'b0;
    run_instr(LW, 6'b000000, 1'b0, 1, 1, "lw_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
